classifier_feeder: RTL
======================

Name: classifier_feeder

Overview:
- Initiator that drives the classifier's stream inputs for one inference and collects its result.
- On `start`, latches a packed bias word and sends it on the b stream.
- Then fetches NUM_INPUTS (pixel, packed-weight) pairs from an external synchronous RAM and streams them on x/w.
- Finally accepts one result beat from the a stream and reports it.
- Sits between the image/weight memory and the classifier in the milestone top level.

Parameters:
- NUM_CLASSES, 10, number of classes; also the number of 4-bit lanes in w/b.
- DW, 4, bit width of a pixel, a weight lane and a bias lane.
- NUM_INPUTS, 784, pixel beats per inference.
- ADDR_W, 10, RAM address width; must satisfy 2^ADDR_W >= NUM_INPUTS.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; ignored unless in IDLE.
- bias_in  in  NUM_CLASSES*DW  bias word; latched when `start` is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a result is captured.
- result_class  out  DW  captured a_tdata.
- result_raw  out  16  captured raw.
- perf_cycles  out  32  cycle count, start to done (optional feature).
- mem_en  out  1  RAM read enable.
- mem_addr  out  ADDR_W  RAM read address.
- mem_x  in  DW  pixel; valid one cycle after mem_en.
- mem_w  in  NUM_CLASSES*DW  packed weights; valid one cycle after mem_en.
- x_tdata  out  DW  pixel stream data.
- x_tvalid  out  1  pixel stream valid.
- x_tready  in  1  pixel stream ready.
- w_tdata  out  NUM_CLASSES*DW  weight stream data.
- w_tvalid  out  1  weight stream valid.
- w_tready  in  1  weight stream ready.
- b_tdata  out  NUM_CLASSES*DW  bias stream data.
- b_tvalid  out  1  bias stream valid.
- b_tready  in  1  bias stream ready.
- a_tdata  in  DW  result stream class.
- raw  in  16  raw score accompanying a_tdata.
- a_tvalid  in  1  result stream valid.
- a_tready  out  1  result stream ready.

Behaviour:
- Reset (RST low, asynchronous):
  - State goes to IDLE; address and skid buffer are cleared.
  - All outputs are 0, including tvalids, a_tready, done, busy, results and perf_cycles.
  - Reset mid-inference abandons the inference; no partial handshake is completed.
- Handshake rules:
  - A transfer occurs when tvalid and tready are both high at a rising edge.
  - tvalid never depends combinationally on tready.
  - tdata is held stable while tvalid is high and the beat has not yet transferred.
- FSM IDLE:
  - `start` latches bias_in, clears the address and goes to BIAS.
  - `start` is ignored in every other state.
- FSM BIAS:
  - b_tvalid = 1 with the latched bias.
  - Prefetch of address 0 may begin in this state.
  - On b transfer, go to STREAM.
- FSM STREAM, memory side:
  - A read is issued (mem_en = 1, mem_addr = next address) when skid occupancy plus in-flight reads is less than 2, and the address is below NUM_INPUTS.
  - Returned data enters a 2-entry skid buffer.
- FSM STREAM, stream side:
  - The head entry drives x_tdata and w_tdata, with x_tvalid = w_tvalid = 1.
  - Channels complete independently. Per-channel flags x_sent and w_sent are set on each channel's own handshake, and that channel's tvalid then drops.
  - The head entry retires when both channels have completed; both flags then clear.
  - Back-to-back retirement gives 1 pair per cycle when both readies are held high.
  - After beat NUM_INPUTS-1 retires, go to RESULT.
- FSM RESULT:
  - a_tready = 1.
  - On a transfer, capture a_tdata and raw, pulse done for one cycle and return to IDLE.
  - Results hold until the next capture.
- Latency and boundaries:
  - With all readies high: b beat in cycle 1 after start; first x/w beat by cycle 2; last by cycle NUM_INPUTS+2.
  - x and w never get out of step by more than one beat.
  - An early a_tvalid, before RESULT, is not accepted (a_tready = 0).
  - The address counter saturates at NUM_INPUTS and never wraps.

Optional Feature:
- Macro: CLASSIFIER_FEEDER_PERF_EN.
- Defined: a 32-bit counter clears on accepted start and increments every cycle while busy. perf_cycles is updated with the final count on the done cycle and holds it after. The counter saturates at all-ones.
- Undefined: no counter is built and perf_cycles is tied to 0.

Decomposition:
- Shared package/header holds:
  - NUM_CLASSES, DW and the raw width (16);
  - the state encoding: IDLE=0, BIAS=1, STREAM=2, RESULT=3.
- One sub-module: feeder_skid_buf, the 2-entry data buffer with occupancy count, push/pop and a can_issue output accounting for the in-flight read.

Test Plan:
- All readies high, NUM_INPUTS=4, RAM holding x=addr+1 and w lane i = i-6 → b beat in cycle 1, x beats 1,2,3,4 on consecutive cycles, a_tready in RESULT. a_tvalid with class 7, raw 0x0123 → done pulse, result_class=7, result_raw=0x0123.
- w_tready low for 3 cycles while x_tready stays high → x transfers once then x_tvalid drops, w completes later, and no beat is duplicated or skipped (x sequence 1,2,3,4 is intact).
- Both readies toggling on a random 50% pattern over 784 beats → exactly 784 x and 784 w handshakes, and mem_addr never exceeds 783.
- `start` pulsed during STREAM, and a_tvalid asserted during BIAS → both ignored; only one b beat is sent.
- RST low at beat 2 → all outputs go to 0 immediately; a fresh start then gives a complete inference from address 0.
- With CLASSIFIER_FEEDER_PERF_EN defined and all readies high at NUM_INPUTS=4 → perf_cycles equals the measured start-to-done cycle count; without the macro, perf_cycles stays 0.

Source files
------------

// File: rtl/classifier_feeder_pkg.sv
// classifier_feeder_pkg
// Shared constants and types for the classifier feeder:
//   NUM_CLASSES / DW  - lane count and lane width of the w and b words
//   RAW_W             - width of the raw score that accompanies a result
//   IDLE..RESULT      - FSM state encoding
//   pair_t            - one (pixel, packed-weight) pair as read from RAM
package classifier_feeder_pkg;

    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned DW          = 4;
    localparam int unsigned RAW_W       = 16;
    localparam int unsigned WW          = NUM_CLASSES * DW;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BIAS   = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;

    typedef struct packed {
        logic [DW-1:0] x;
        logic [WW-1:0] w;
    } pair_t;

endpackage

// File: rtl/feeder_skid_buf.sv
// feeder_skid_buf
// Two-entry buffer between the synchronous RAM and the x/w streams.
// Ports:
//   CLK, RST    clock, asynchronous active-low reset
//   rd_issue    a RAM read is issued this cycle (data arrives next cycle)
//   rd_data     RAM read data, valid the cycle after rd_issue
//   pop         head entry retires this cycle (only while head_valid)
//   head        current head pair
//   head_valid  head holds real data
//   can_issue   another read fits once this cycle's pop is accounted for
// When the buffer is empty the arriving RAM word is presented directly as
// the head, so a pair can stream out in the same cycle it returns.
module feeder_skid_buf
    import classifier_feeder_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  rd_issue,
    input  pair_t rd_data,
    input  logic  pop,
    output pair_t head,
    output logic  head_valid,
    output logic  can_issue
);

    pair_t      entry_q [2];
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] count_q;
    logic       inflight_q;

    logic       stored;
    logic       push;
    logic       pop_stored;
    logic [2:0] occ_after;

    assign stored     = (count_q != 2'd0);
    assign head_valid = stored | inflight_q;
    assign head       = stored ? entry_q[rd_ptr_q] : rd_data;

    // An arriving word consumed straight from the bypass is never stored.
    assign pop_stored = pop & stored;
    assign push       = inflight_q & ~(pop & ~stored);

    // Occupancy including the in-flight read, after this cycle's retirement.
    assign occ_after  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop & head_valid};
    assign can_issue  = (occ_after < 3'd2);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_issue;
            if (push) begin
                entry_q[wr_ptr_q] <= rd_data;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop_stored) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop_stored};
        end
    end

endmodule

// File: rtl/classifier_feeder.sv
// classifier_feeder
// Drives one classifier inference: sends the bias word on b, streams
// NUM_INPUTS (pixel, weight) pairs fetched from RAM on x/w, then accepts a
// single result beat on a.
// Ports:
//   CLK, RST                      clock, asynchronous active-low reset
//   start, bias_in                request (IDLE only) and bias word to send
//   busy, done                    not-IDLE flag, one-cycle capture pulse
//   result_class, result_raw      captured a_tdata / raw, held until next capture
//   perf_cycles                   busy-cycle count of the last inference
//   mem_en, mem_addr, mem_x/mem_w synchronous RAM read port (1-cycle latency)
//   x_*, w_*, b_*                 outgoing valid/ready streams
//   a_tdata, raw, a_tvalid/ready  incoming result stream
// Build option: define CLASSIFIER_FEEDER_PERF_EN to build the 32-bit
// saturating cycle counter; otherwise perf_cycles is tied to 0.
module classifier_feeder
    import classifier_feeder_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 784,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [WW-1:0]     bias_in,
    output logic              busy,
    output logic              done,
    output logic [DW-1:0]     result_class,
    output logic [RAW_W-1:0]  result_raw,
    output logic [31:0]       perf_cycles,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DW-1:0]     mem_x,
    input  logic [WW-1:0]     mem_w,
    output logic [DW-1:0]     x_tdata,
    output logic              x_tvalid,
    input  logic              x_tready,
    output logic [WW-1:0]     w_tdata,
    output logic              w_tvalid,
    input  logic              w_tready,
    output logic [WW-1:0]     b_tdata,
    output logic              b_tvalid,
    input  logic              b_tready,
    input  logic [DW-1:0]     a_tdata,
    input  logic [RAW_W-1:0]  raw,
    input  logic              a_tvalid,
    output logic              a_tready
);

    localparam logic [ADDR_W:0] NUM_IN = (ADDR_W + 1)'(NUM_INPUTS);
    localparam logic [ADDR_W:0] LAST   = (ADDR_W + 1)'(NUM_INPUTS - 1);
    localparam logic [ADDR_W:0] ONE    = (ADDR_W + 1)'(1);

    logic [1:0]       state_q, state_d;
    logic [WW-1:0]    bias_q;
    logic [ADDR_W:0]  addr_q;   // one extra bit so it can rest at NUM_INPUTS
    logic [ADDR_W:0]  beat_q;
    logic             x_sent_q, w_sent_q;
    logic             done_q;
    logic [DW-1:0]    result_class_q;
    logic [RAW_W-1:0] result_raw_q;

    logic  start_ok;
    logic  rd_issue;
    logic  can_issue;
    logic  head_valid;
    logic  head_ok;
    logic  x_hs, w_hs, b_hs, a_hs;
    logic  pop;
    pair_t head;
    pair_t mem_pair;

    assign mem_pair.x = mem_x;
    assign mem_pair.w = mem_w;

    feeder_skid_buf u_skid (
        .CLK        (CLK),
        .RST        (RST),
        .rd_issue   (rd_issue),
        .rd_data    (mem_pair),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .can_issue  (can_issue)
    );

    assign start_ok = start && (state_q == IDLE);

    // Prefetch starts while the bias beat is still pending.
    assign rd_issue = ((state_q == BIAS) || (state_q == STREAM)) && can_issue &&
                      (addr_q < NUM_IN);
    assign mem_en   = rd_issue;
    assign mem_addr = rd_issue ? addr_q[ADDR_W-1:0] : '0;

    // Each channel drops its valid once it has transferred the head pair.
    assign head_ok  = (state_q == STREAM) && head_valid;
    assign x_tvalid = head_ok && !x_sent_q;
    assign w_tvalid = head_ok && !w_sent_q;
    assign x_tdata  = head_ok ? head.x : '0;
    assign w_tdata  = head_ok ? head.w : '0;
    assign x_hs     = x_tvalid && x_tready;
    assign w_hs     = w_tvalid && w_tready;
    assign pop      = head_ok && (x_sent_q || x_hs) && (w_sent_q || w_hs);

    assign b_tvalid = (state_q == BIAS);
    assign b_tdata  = b_tvalid ? bias_q : '0;
    assign b_hs     = b_tvalid && b_tready;

    assign a_tready = (state_q == RESULT);
    assign a_hs     = a_tready && a_tvalid;

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign result_class = result_class_q;
    assign result_raw   = result_raw_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = BIAS;
            BIAS:    if (b_hs) state_d = STREAM;
            STREAM:  if (pop && (beat_q == LAST)) state_d = RESULT;
            RESULT:  if (a_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= IDLE;
            bias_q         <= '0;
            addr_q         <= '0;
            beat_q         <= '0;
            x_sent_q       <= 1'b0;
            w_sent_q       <= 1'b0;
            done_q         <= 1'b0;
            result_class_q <= '0;
            result_raw_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= a_hs;
            if (start_ok) begin
                bias_q <= bias_in;
                addr_q <= '0;
                beat_q <= '0;
            end else begin
                if (rd_issue) addr_q <= addr_q + ONE;
                if (pop)      beat_q <= beat_q + ONE;
            end
            if (pop) begin
                x_sent_q <= 1'b0;
                w_sent_q <= 1'b0;
            end else begin
                if (x_hs) x_sent_q <= 1'b1;
                if (w_hs) w_sent_q <= 1'b1;
            end
            if (a_hs) begin
                result_class_q <= a_tdata;
                result_raw_q   <= raw;
            end
        end
    end

`ifdef CLASSIFIER_FEEDER_PERF_EN
    logic [31:0] perf_cnt_q;
    logic [31:0] perf_q;
    logic [31:0] perf_cnt_inc;

    assign perf_cnt_inc = (perf_cnt_q == '1) ? perf_cnt_q : perf_cnt_q + 32'd1;
    assign perf_cycles  = perf_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            perf_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            if (start_ok) begin
                perf_cnt_q <= '0;
            end else if (busy) begin
                perf_cnt_q <= perf_cnt_inc;
            end
            // The capture cycle is still busy, so it is included.
            if (a_hs) perf_q <= perf_cnt_inc;
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule
